// File: rtl/mem_trap_ctrl_if.sv
// mem_trap_ctrl_if: memory-stage side bundle of the trap sequencer.
// master = trap controller, slave = memory stage / fetch.
interface mem_trap_ctrl_if;
  logic        i_int;
  logic [1:0]  i_changeEPC;
  logic        i_stall;
  logic [31:0] i_memData;
  logic        o_busy;
  logic        o_isStack;
  logic        o_isPushPc;
  logic        o_memRead;
  logic        o_memWrite;
  logic        o_en32;
  logic [2:0]  o_SP_select;
  logic [15:0] o_aluAddr;
  logic        o_flush;
  logic        o_stallFetch;
  logic        o_pcLoad;
  logic [31:0] o_pcValue;
  logic        o_irqAck;
  logic        o_reset_epc;

  modport master (
    input  i_int, i_changeEPC, i_stall, i_memData,
    output o_busy, o_isStack, o_isPushPc, o_memRead,
    output o_memWrite, o_en32, o_SP_select, o_aluAddr,
    output o_flush, o_stallFetch, o_pcLoad, o_pcValue,
    output o_irqAck, o_reset_epc
  );

  modport slave (
    output i_int, i_changeEPC, i_stall, i_memData,
    input  o_busy, o_isStack, o_isPushPc, o_memRead,
    input  o_memWrite, o_en32, o_SP_select, o_aluAddr,
    input  o_flush, o_stallFetch, o_pcLoad, o_pcValue,
    input  o_irqAck, o_reset_epc
  );
endinterface

// File: rtl/mem_trap_ctrl.sv
// mem_trap_ctrl: exception / interrupt entry sequencer
// beside the memory stage (push PC, fetch vector, redirect).
module mem_trap_ctrl #(
  parameter logic [15:0] INT_VEC_ADDR  = 16'h0006,
  parameter logic [15:0] EXC1_VEC_ADDR = 16'h0002,
  parameter logic [15:0] EXC2_VEC_ADDR = 16'h0004,
  parameter int unsigned DRAIN_CYCLES  = 3
) (
  input  logic clk,
  input  logic i_reset,
  mem_trap_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_PUSH, S_VEC_RD, S_LOAD
  } state_t;

  localparam logic [1:0] C_INT  = 2'b00;
  localparam logic [1:0] C_EXC1 = 2'b01;
  localparam logic [1:0] C_EXC2 = 2'b10;
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t      r_state;
  logic [1:0]  r_cause;
  logic        r_pend;
  logic [3:0]  r_cnt;
  logic        r_int_q;
  logic        r_rst_epc;

  state_t      w_state_n;
  logic [1:0]  w_cause_n;
  logic [3:0]  w_cnt_n;
  logic        w_pend_clr;
  logic        w_exc;
  logic [1:0]  w_exc_cause;
  logic        w_int_edge;
  logic [15:0] w_vec;

  assign w_exc       = |bus.i_changeEPC;
  assign w_exc_cause = bus.i_changeEPC[1] ? C_EXC2 : C_EXC1;
  assign w_int_edge  = bus.i_int & ~r_int_q;

  // state, cause, drain counter, pending flag and int history
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cause   <= C_INT;
      r_pend    <= 1'b0;
      r_cnt     <= '0;
      r_int_q   <= 1'b0;
      r_rst_epc <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_cause   <= w_cause_n;
      r_cnt     <= w_cnt_n;
      r_int_q   <= bus.i_int;
      r_pend    <= w_int_edge | (r_pend & ~w_pend_clr);
      r_rst_epc <= 1'b0;
    end
  end

  // next state: exception beats interrupt in IDLE and DRAIN
  always_comb begin
    w_state_n  = r_state;
    w_cause_n  = r_cause;
    w_cnt_n    = r_cnt;
    w_pend_clr = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_exc) begin
          w_cause_n = w_exc_cause;
          w_state_n = S_VEC_RD;
        end else if (r_pend && !bus.i_stall) begin
          w_cnt_n   = DRAIN_INIT;
          w_state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_exc) begin
          w_cause_n = w_exc_cause;
          w_state_n = S_VEC_RD;
        end else if (r_cnt <= 4'd1) begin
          w_pend_clr = 1'b1;
          w_state_n  = S_PUSH;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
      S_PUSH: begin
        w_cause_n = C_INT;
        w_state_n = S_VEC_RD;
      end
      S_VEC_RD: w_state_n = S_LOAD;
      S_LOAD:   w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  // vector address for the latched cause
  always_comb begin
    unique case (r_cause)
      C_EXC1:  w_vec = EXC1_VEC_ADDR;
      C_EXC2:  w_vec = EXC2_VEC_ADDR;
      default: w_vec = INT_VEC_ADDR;
    endcase
  end

  assign bus.o_reset_epc = i_reset | r_rst_epc;

  // memory-stage controls per state, all quiet during reset
  always_comb begin
    bus.o_busy       = 1'b0;
    bus.o_isStack    = 1'b0;
    bus.o_isPushPc   = 1'b0;
    bus.o_memRead    = 1'b0;
    bus.o_memWrite   = 1'b0;
    bus.o_en32       = 1'b0;
    bus.o_SP_select  = 3'b000;
    bus.o_aluAddr    = 16'h0000;
    bus.o_flush      = 1'b0;
    bus.o_stallFetch = 1'b0;
    bus.o_pcLoad     = 1'b0;
    bus.o_pcValue    = 32'h0;
    bus.o_irqAck     = 1'b0;
    if (!i_reset) begin
      bus.o_busy = (r_state != S_IDLE);
      unique case (r_state)
        S_IDLE: bus.o_flush = w_exc;
        S_DRAIN: begin
          bus.o_stallFetch = 1'b1;
          bus.o_flush      = w_exc;
        end
        S_PUSH: begin
          bus.o_isStack    = 1'b1;
          bus.o_isPushPc   = 1'b1;
          bus.o_memWrite   = 1'b1;
          bus.o_en32       = 1'b1;
          bus.o_SP_select  = 3'b001;
          bus.o_stallFetch = 1'b1;
        end
        S_VEC_RD: begin
          bus.o_memRead    = 1'b1;
          bus.o_en32       = 1'b1;
          bus.o_aluAddr    = w_vec;
          bus.o_stallFetch = 1'b1;
        end
        S_LOAD: begin
          bus.o_pcLoad  = 1'b1;
          bus.o_pcValue = bus.i_memData;
          bus.o_irqAck  = (r_cause == C_INT);
        end
        default: bus.o_busy = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_trap_ctrl.sv
// tb_mem_trap_ctrl: directed bench for the trap sequencer.
// Inputs driven and outputs sampled just after the falling edge.
module tb_mem_trap_ctrl;

  logic clk;
  logic i_reset;
  int   checks;
  int   errors;
  int   acks;
  int   wrs;

  mem_trap_ctrl_if bus ();

  mem_trap_ctrl #(
    .INT_VEC_ADDR (16'h0006),
    .EXC1_VEC_ADDR(16'h0002),
    .EXC2_VEC_ADDR(16'h0004),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk    (clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_reset = 1'b1;
    bus.i_int = 1'b0;
    bus.i_changeEPC = 2'b00;
    bus.i_stall = 1'b0;
    bus.i_memData = 32'h0;

    // reset state and release
    @(negedge clk); #1;
    chk("rst_epc", 32'(bus.o_reset_epc), 1);
    chk("rst_busy", 32'(bus.o_busy), 0);
    @(negedge clk); i_reset = 1'b0; #1;
    chk("rel_epc_hold", 32'(bus.o_reset_epc), 1);
    @(negedge clk); #1;
    chk("rel_epc_clr", 32'(bus.o_reset_epc), 0);
    chk("rel_busy", 32'(bus.o_busy), 0);

    // interrupt entry
    @(negedge clk); bus.i_int = 1'b1; #1;
    chk("int_edge_busy", 32'(bus.o_busy), 0);
    @(negedge clk); #1;
    chk("int_pend_busy", 32'(bus.o_busy), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("int_drain_stall", 32'(bus.o_stallFetch), 1);
      chk("int_drain_busy", 32'(bus.o_busy), 1);
      chk("int_drain_wr", 32'(bus.o_memWrite), 0);
    end
    @(negedge clk); #1;
    chk("push_stack", 32'(bus.o_isStack), 1);
    chk("push_pc", 32'(bus.o_isPushPc), 1);
    chk("push_wr", 32'(bus.o_memWrite), 1);
    chk("push_en32", 32'(bus.o_en32), 1);
    chk("push_sp", 32'(bus.o_SP_select), 1);
    chk("push_stall", 32'(bus.o_stallFetch), 1);
    @(negedge clk); #1;
    chk("int_vec_rd", 32'(bus.o_memRead), 1);
    chk("int_vec_addr", 32'(bus.o_aluAddr), 32'h6);
    chk("int_vec_stack", 32'(bus.o_isStack), 0);
    chk("int_vec_wr", 32'(bus.o_memWrite), 0);
    @(negedge clk); bus.i_memData = 32'h0000_0120; #1;
    chk("int_load", 32'(bus.o_pcLoad), 1);
    chk("int_pcval", bus.o_pcValue, 32'h120);
    chk("int_ack", 32'(bus.o_irqAck), 1);
    chk("int_load_rd", 32'(bus.o_memRead), 0);
    @(negedge clk); bus.i_int = 1'b0; #1;
    chk("int_done_busy", 32'(bus.o_busy), 0);
    chk("int_done_load", 32'(bus.o_pcLoad), 0);

    // exception entry, cause 10 then cause 11
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.i_changeEPC = (k == 0) ? 2'b10 : 2'b11;
      #1;
      chk("exc_flush", 32'(bus.o_flush), 1);
      chk("exc_flush_wr", 32'(bus.o_memWrite), 0);
      @(negedge clk); bus.i_changeEPC = 2'b00; #1;
      chk("exc_flush_off", 32'(bus.o_flush), 0);
      chk("exc_rd", 32'(bus.o_memRead), 1);
      chk("exc_addr", 32'(bus.o_aluAddr), 32'h4);
      chk("exc_rd_wr", 32'(bus.o_memWrite), 0);
      @(negedge clk); bus.i_memData = 32'hDEAD_BEEF; #1;
      chk("exc_load", 32'(bus.o_pcLoad), 1);
      chk("exc_pcval", bus.o_pcValue, 32'hDEAD_BEEF);
      chk("exc_ack", 32'(bus.o_irqAck), 0);
      @(negedge clk); #1;
      chk("exc_idle", 32'(bus.o_busy), 0);
    end

    // simultaneous exception and interrupt edge
    @(negedge clk);
    bus.i_changeEPC = 2'b01;
    bus.i_int = 1'b1;
    #1;
    chk("sim_flush", 32'(bus.o_flush), 1);
    @(negedge clk); bus.i_changeEPC = 2'b00; #1;
    chk("sim_exc_addr", 32'(bus.o_aluAddr), 32'h2);
    @(negedge clk); bus.i_memData = 32'h200; #1;
    chk("sim_exc_pc", bus.o_pcValue, 32'h200);
    chk("sim_exc_ack", 32'(bus.o_irqAck), 0);
    @(negedge clk); #1;
    chk("sim_gap_busy", 32'(bus.o_busy), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("sim_drain", 32'(bus.o_stallFetch), 1);
    end
    @(negedge clk); #1;
    chk("sim_push", 32'(bus.o_memWrite), 1);
    @(negedge clk); #1;
    chk("sim_int_addr", 32'(bus.o_aluAddr), 32'h6);
    @(negedge clk); bus.i_memData = 32'h300; #1;
    chk("sim_int_pc", bus.o_pcValue, 32'h300);
    chk("sim_int_ack", 32'(bus.o_irqAck), 1);
    @(negedge clk); bus.i_int = 1'b0; #1;
    chk("sim_idle", 32'(bus.o_busy), 0);

    // stall gating with two merged edges
    @(negedge clk);
    bus.i_stall = 1'b1;
    bus.i_int = 1'b1;
    #1;
    chk("stl_busy0", 32'(bus.o_busy), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) bus.i_int = 1'b0;
      if (i == 3) bus.i_int = 1'b1;
      #1;
      chk("stl_hold", 32'(bus.o_busy), 0);
    end
    @(negedge clk); bus.i_stall = 1'b0; #1;
    chk("stl_rel_idle", 32'(bus.o_busy), 0);
    @(negedge clk); #1;
    chk("stl_drain", 32'(bus.o_stallFetch), 1);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (bus.o_irqAck) acks++;
    end
    chk("stl_one_ack", 32'(acks), 1);
    chk("stl_end_idle", 32'(bus.o_busy), 0);
    bus.i_int = 1'b0;

    // exception preempts drain
    @(negedge clk); bus.i_int = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("pre_d1", 32'(bus.o_stallFetch), 1);
    @(negedge clk); bus.i_changeEPC = 2'b01; #1;
    chk("pre_flush", 32'(bus.o_flush), 1);
    chk("pre_no_wr", 32'(bus.o_memWrite), 0);
    chk("pre_busy", 32'(bus.o_busy), 1);
    @(negedge clk); bus.i_changeEPC = 2'b00; #1;
    chk("pre_rd", 32'(bus.o_memRead), 1);
    chk("pre_addr", 32'(bus.o_aluAddr), 32'h2);
    @(negedge clk); bus.i_memData = 32'h400; #1;
    chk("pre_pc", bus.o_pcValue, 32'h400);
    chk("pre_ack", 32'(bus.o_irqAck), 0);
    acks = 0;
    wrs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.o_irqAck) acks++;
      if (bus.o_memWrite) wrs++;
    end
    chk("pre_int_ack", 32'(acks), 1);
    chk("pre_int_push", 32'(wrs), 1);
    bus.i_int = 1'b0;

    // reset in the middle of drain
    @(negedge clk); bus.i_int = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("mr_drain", 32'(bus.o_busy), 1);
    @(negedge clk);
    i_reset = 1'b1;
    bus.i_int = 1'b0;
    #1;
    chk("mr_busy", 32'(bus.o_busy), 0);
    chk("mr_stall", 32'(bus.o_stallFetch), 0);
    chk("mr_epc", 32'(bus.o_reset_epc), 1);
    chk("mr_wr", 32'(bus.o_memWrite), 0);
    @(negedge clk); i_reset = 1'b0; #1;
    chk("mr_rel_epc", 32'(bus.o_reset_epc), 1);
    @(negedge clk); #1;
    chk("mr_epc_clr", 32'(bus.o_reset_epc), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("mr_idle", 32'(bus.o_busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
